instruction_fetch_unit: RTL

// - Consumes PCResult from ProgramCounter and fetches the instruction through a req/ready instruction-memory port.
// - Loads the IF/ID pipeline register: instruction, PC+4, valid.
// - Drives PC_Write back to ProgramCounter so the PC advances only when a fetch is consumed or a flush redirects it.
// - Absorbs ID-stage stalls with a one-entry skid buffer and squashes work on branch flush.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/if_id_skid_buffer.sv | 63 ++++++
 rtl/instruction_fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
//   - state_t  : fetch FSM states (2-bit encoding)
//   - if_id_t  : IF/ID payload {instr, pc_plus4}
//   - defaults : address/data widths, PC increment, NOP encoding
package fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_PC_INC    = 32'd4;
    localparam logic [DATA_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/if_id_skid_buffer.sv
// One-entry skid buffer in front of the IF/ID pipeline register.
//   clk, reset   : clock, synchronous active-high reset
//   load         : a fetch response is accepted this cycle
//   load_data    : payload of that response
//   stall        : ID hazard, hold IF/ID (a response is parked in the buffer)
//   flush        : squash IF/ID and the buffer
//   if_id        : IF/ID payload
//   if_id_valid  : IF/ID payload valid
//   skid_full    : buffer holds a parked response
module if_id_skid_buffer
    import fetch_pkg::*;
#(
    parameter logic [DATA_W-1:0] NOP = DEFAULT_NOP_INSTR
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  if_id_t load_data,
    input  logic   stall,
    input  logic   flush,
    output if_id_t if_id,
    output logic   if_id_valid,
    output logic   skid_full
);

    if_id_t skid_data;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_valid    <= 1'b0;
            if_id.instr    <= NOP;
            if_id.pc_plus4 <= '0;
            skid_full      <= 1'b0;
        end else if (flush) begin
            if_id_valid <= 1'b0;
            if_id.instr <= NOP;
            skid_full   <= 1'b0;
        end else if (stall) begin
            // IF/ID holds; a response arriving now is parked.
            if (load) skid_full <= 1'b1;
        end else if (skid_full) begin
            // Drain: the FSM never accepts a response while the buffer is full.
            if_id       <= skid_data;
            if_id_valid <= 1'b1;
            skid_full   <= 1'b0;
        end else if (load) begin
            if_id       <= load_data;
            if_id_valid <= 1'b1;
        end else begin
            if_id_valid <= 1'b0;
            if_id.instr <= NOP;
        end
    end

    // NOTE: the payload is deliberately not reset; skid_full qualifies it,
    // so its power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (!reset && !flush && stall && load) skid_data <= load_data;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues fetches for PCResult over a req/ready
// memory port, loads IF/ID through a one-entry skid buffer, and tells the
// ProgramCounter when to advance.
//   Clk, Reset          : clock, synchronous active-high reset
//   PCResult            : current PC
//   PC_Write            : PC load enable (combinational)
//   IMemReq, IMemAddr   : registered memory request, address stable while Req=1
//   IMemReady, IMemData : response strobe and instruction
//   Stall, Flush        : ID hazard hold, branch-taken squash
//   IF_ID_*             : IF/ID pipeline register
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] PC_INC    = DEFAULT_PC_INC,
    parameter logic [DATA_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PCResult,
    output logic              PC_Write,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemReady,
    input  logic [DATA_W-1:0] IMemData,
    input  logic              Stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] IF_ID_Instruction,
    output logic [ADDR_W-1:0] IF_ID_PCPlus4,
    output logic              IF_ID_Valid
);

    state_t state;
    logic   accept;
    logic   skid_full;
    logic   can_issue;
    if_id_t resp;
    if_id_t if_id;

    // A fetch is consumed only in WAIT without a flush; DROP discards.
    assign accept    = (state == ST_WAIT) && IMemReady && !Flush;
    assign PC_Write  = accept || Flush;
    // The buffer counts as empty when it is draining this very cycle.
    assign can_issue = (!skid_full || !Stall) && !Flush;

    // PC+4 comes from the latched request address; wraps silently.
    assign resp.instr    = IMemData;
    assign resp.pc_plus4 = IMemAddr + PC_INC;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_ISSUE;
            IMemReq  <= 1'b0;
            IMemAddr <= '0;
        end else begin
            case (state)
                ST_ISSUE: begin
                    if (can_issue) begin
                        IMemReq  <= 1'b1;
                        IMemAddr <= PCResult;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (IMemReady) begin
                        IMemReq <= 1'b0;
                        state   <= ST_ISSUE;
                    end else if (Flush) begin
                        state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (IMemReady) begin
                        IMemReq <= 1'b0;
                        state   <= ST_ISSUE;
                    end
                end
                default: begin
                    IMemReq <= 1'b0;
                    state   <= ST_ISSUE;
                end
            endcase
        end
    end

    if_id_skid_buffer #(
        .NOP(NOP_INSTR)
    ) u_skid (
        .clk        (Clk),
        .reset      (Reset),
        .load       (accept),
        .load_data  (resp),
        .stall      (Stall),
        .flush      (Flush),
        .if_id      (if_id),
        .if_id_valid(IF_ID_Valid),
        .skid_full  (skid_full)
    );

    assign IF_ID_Instruction = if_id.instr;
    assign IF_ID_PCPlus4     = if_id.pc_plus4;

endmodule
